// File: rtl/link_serial_rx.sv
// Serial link receiver: 2-flop synchronised line, start/data/stop deserialiser
// and a small FIFO presenting frames on a valid/ready port.
module link_serial_rx #(
    parameter int FRAME_W      = 16,
    parameter int CLKS_PER_BIT = 4,
    parameter int DEPTH        = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               sig_rx,
    output logic               ready_rx,
    output logic [FRAME_W-1:0] frame_data,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic               frame_err,
    output logic               overrun
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW   = (FRAME_W > 2) ? $clog2(FRAME_W) : 1;
    localparam int PW   = $clog2(DEPTH);
    localparam int NW   = PW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic               sync1_q, s_q, s_prev_q;
    logic [CW-1:0]      cyc_q, cyc_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [FRAME_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]      wr_q, rd_q;
    logic [NW-1:0]      count_q, count_d;
    logic [NW:0]        occ_d;
    logic               ready_q, ready_d;
    logic               err_q, err_d, ovr_q, ovr_d;
    logic               push, pop, full;

    assign full        = (count_q == NW'(DEPTH));
    assign frame_valid = (count_q != '0);
    assign pop         = frame_valid & frame_ready;
    assign frame_data  = mem_q[rd_q];
    assign ready_rx    = ready_q;
    assign frame_err   = err_q;
    assign overrun     = ovr_q;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        push    = 1'b0;
        err_d   = 1'b0;
        ovr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_prev_q && !s_q) begin
                    state_d = START;
                    cyc_d   = '0;
                end
            end
            START: begin
                if (cyc_q == CW'(HALF - 1)) begin
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = s_q ? IDLE : DATA;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            DATA: begin
                if (cyc_q == CW'(CLKS_PER_BIT - 1)) begin
                    cyc_d   = '0;
                    // LSB arrives first, so shifting in from the top leaves it at bit 0
                    shift_d = {s_q, shift_q[FRAME_W-1:1]};
                    if (bit_q == BW'(FRAME_W - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            STOP: begin
                if (cyc_q == CW'(CLKS_PER_BIT - 1)) begin
                    cyc_d   = '0;
                    state_d = IDLE;
                    if (!s_q) begin
                        err_d = 1'b1;
                    end else if (full) begin
                        ovr_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        // Frame being received already reserves a slot
        occ_d   = {1'b0, count_d} + {{NW{1'b0}}, (state_d != IDLE)};
        ready_d = (occ_d < (NW + 1)'(DEPTH));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q  <= 1'b1;
            s_q      <= 1'b1;
            s_prev_q <= 1'b1;
            state_q  <= IDLE;
            cyc_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sync1_q  <= sig_rx;
            s_q      <= sync1_q;
            s_prev_q <= s_q;
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            ovr_q    <= ovr_d;
            if (push) begin
                mem_q[wr_q] <= shift_q;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

endmodule
